// File: rtl/sync_timing_rec_pkg.sv
// Shared types and default constants for the symbol-timing recovery block.
// Imported by the interface, the argmax helper and the top.
package sync_pkg;

  localparam int S_IN_DEF     = 10;
  localparam int OS_DEF       = 4;
  localparam int WIN_LOG2_DEF = 4;
  localparam int THR_DEF      = 77;
  localparam int LOSS_WIN_DEF = 2;

  typedef enum logic {
    ACQUIRE = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  // Summing 2^win_log2 magnitudes of at most 2^(s_in-1) never exceeds s_in+win_log2 bits.
  function automatic int acc_width(input int s_in, input int win_log2);
    return s_in + win_log2;
  endfunction

endpackage

// File: rtl/sync_timing_rec_if.sv
// Sample-in / strobe-out bundle between the RC filter, the timing recovery and the slicer.
// Inputs are plain per-cycle qualifiers: a sample is taken on any cycle with i_enable && i_valid.
interface sync_timing_rec_if
  import sync_pkg::*;
#(
  parameter int S_IN = S_IN_DEF,
  parameter int PH_W = 2
);
  logic            i_enable;
  logic            i_valid;
  logic            i_restart;
  logic [S_IN-1:0] i_rc_filter;
  logic            o_sync;
  logic [PH_W-1:0] o_phase;
  logic            o_strobe;
  logic [S_IN-1:0] o_sample;
  state_t          dbg_state;

  modport master (
    output i_enable, i_valid, i_restart, i_rc_filter,
    input  o_sync, o_phase, o_strobe, o_sample, dbg_state
  );

  modport slave (
    input  i_enable, i_valid, i_restart, i_rc_filter,
    output o_sync, o_phase, o_strobe, o_sample, dbg_state
  );
endinterface

// File: rtl/sync_timing_rec_argmax.sv
// Combinational argmax over N unsigned values; the lowest index wins a tie.
module sync_argmax #(
  parameter int N  = 4,
  parameter int W  = 14,
  parameter int IW = 2
) (
  input  logic [W-1:0]  vals [N],
  output logic [IW-1:0] idx,
  output logic [W-1:0]  max_val
);

  always_comb begin
    idx     = '0;
    max_val = vals[0];
    // Strict compare keeps the earlier index on equal energies.
    for (int k = 1; k < N; k++) begin
      if (vals[k] > max_val) begin
        max_val = vals[k];
        idx     = IW'(k);
      end
    end
  end

endmodule

// File: rtl/sync_timing_rec.sv
// Symbol-timing acquisition: per-phase |x| energy over a window, max-energy phase selection,
// lock/track/loss state machine, and a strobe carrying the sample at the chosen phase.
module sync_timing_rec
  import sync_pkg::*;
#(
  parameter int S_IN     = S_IN_DEF,
  parameter int OS       = OS_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int THR      = THR_DEF,
  parameter int LOSS_WIN = LOSS_WIN_DEF
) (
  input logic              clock,
  input logic              i_reset,
  sync_timing_rec_if.slave bus
);

  localparam int PH_W  = (OS > 1) ? $clog2(OS) : 1;
  localparam int ACC_W = acc_width(S_IN, WIN_LOG2);
  localparam int LC_W  = $clog2(LOSS_WIN + 1);
  localparam logic [ACC_W-1:0] THR_WIN = ACC_W'(THR) << WIN_LOG2;

  state_t              state, state_nx;
  logic [PH_W-1:0]     phase_q, phase_nx;
  logic [LC_W-1:0]     loss_cnt, loss_nx;
  logic [PH_W-1:0]     phase_cnt;
  logic [WIN_LOG2-1:0] sym_cnt;
  logic [ACC_W-1:0]    acc    [OS];
  logic [ACC_W-1:0]    shadow [OS];
  logic                eval_pend;
  logic                strobe_q;
  logic [S_IN-1:0]     sample_q;

  logic                accepted, win_close, pass;
  logic [S_IN-1:0]     mag;
  logic [PH_W-1:0]     best;
  logic [ACC_W-1:0]    best_val;

  assign accepted  = bus.i_enable & bus.i_valid;
  assign win_close = accepted && (phase_cnt == PH_W'(OS - 1)) && (sym_cnt == '1);
  // Unsigned view makes the most negative input come out as 2^(S_IN-1) without saturation.
  assign mag       = bus.i_rc_filter[S_IN-1] ? (~bus.i_rc_filter + 1'b1) : bus.i_rc_filter;

  sync_argmax #(.N(OS), .W(ACC_W), .IW(PH_W)) u_argmax (
    .vals    (shadow),
    .idx     (best),
    .max_val (best_val)
  );

  assign pass = (best_val >= THR_WIN);

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      state    <= ACQUIRE;
      phase_q  <= '0;
      loss_cnt <= '0;
    end else begin
      state    <= state_nx;
      phase_q  <= phase_nx;
      loss_cnt <= loss_nx;
    end
  end

  always_comb begin
    state_nx = state;
    phase_nx = phase_q;
    loss_nx  = loss_cnt;
    if (bus.i_restart) begin
      state_nx = ACQUIRE;
      loss_nx  = '0;
    end else if (bus.i_enable && eval_pend) begin
      case (state)
        ACQUIRE: begin
          if (pass) begin
            state_nx = LOCKED;
            phase_nx = best;
            loss_nx  = '0;
          end
        end
        LOCKED: begin
          if (pass) begin
            phase_nx = best;
            loss_nx  = '0;
          end else if (loss_cnt == LC_W'(LOSS_WIN - 1)) begin
            state_nx = ACQUIRE;
            loss_nx  = '0;
          end else begin
            loss_nx = loss_cnt + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge i_reset) begin
    if (!i_reset) begin
      phase_cnt <= '0;
      sym_cnt   <= '0;
      eval_pend <= 1'b0;
      strobe_q  <= 1'b0;
      sample_q  <= '0;
      for (int k = 0; k < OS; k++) begin
        acc[k]    <= '0;
        shadow[k] <= '0;
      end
    end else if (bus.i_restart) begin
      phase_cnt <= '0;
      sym_cnt   <= '0;
      eval_pend <= 1'b0;
      strobe_q  <= 1'b0;
      for (int k = 0; k < OS; k++) begin
        acc[k]    <= '0;
        shadow[k] <= '0;
      end
    end else if (bus.i_enable) begin
      strobe_q  <= 1'b0;
      eval_pend <= win_close;
      if (accepted) begin
        if (phase_cnt == PH_W'(OS - 1)) begin
          phase_cnt <= '0;
          sym_cnt   <= sym_cnt + 1'b1;
        end else begin
          phase_cnt <= phase_cnt + 1'b1;
        end
        // On the closing sample the shadow takes the completed sums and the live set restarts at 0.
        for (int k = 0; k < OS; k++) begin
          if (win_close) begin
            shadow[k] <= (phase_cnt == PH_W'(k)) ? acc[k] + ACC_W'(mag) : acc[k];
            acc[k]    <= '0;
          end else if (phase_cnt == PH_W'(k)) begin
            acc[k] <= acc[k] + ACC_W'(mag);
          end
        end
        if (state == LOCKED && phase_cnt == phase_q) begin
          strobe_q <= 1'b1;
          sample_q <= bus.i_rc_filter;
        end
      end
    end else begin
      strobe_q <= 1'b0;
    end
  end

  assign bus.o_sync    = (state == LOCKED);
  assign bus.o_phase   = phase_q;
  assign bus.o_strobe  = strobe_q;
  assign bus.o_sample  = sample_q;
  assign bus.dbg_state = state;

endmodule

// File: doc/sync_timing_rec.md
Name: sync_timing_rec

Overview:
- Parametrised successor of the threshold sync detector; performs symbol-timing acquisition on the oversampled raised-cosine filter output.
- Accumulates |sample| energy per oversampling phase over a window of symbols and selects the max-energy phase.
- Declares lock when that phase's energy clears a threshold; tracks the phase while locked; drops lock after consecutive weak windows.
- Sits between the RC filter and the slicer/downsampler; emits a strobe and the sample at the chosen phase.

Parameters:
- S_IN, 10, input sample width (signed two's complement).
- OS, 4, oversampling factor (samples per symbol), 2..8.
- PH_W, $clog2(OS), phase index width.
- WIN_LOG2, 4, window length = 2^WIN_LOG2 symbols (OS*2^WIN_LOG2 valid samples).
- THR, 77, per-sample average magnitude threshold (unsigned, S_IN-1 bits).
- LOSS_WIN, 2, consecutive below-threshold windows that cause loss of lock.
- ACC_W, S_IN+WIN_LOG2, accumulator width (derived, not overridden).

Ports:
- clock, in, 1, system clock.
- i_reset, in, 1, asynchronous, active-low reset.
- i_enable, in, 1, block enable; when low, samples are ignored and all state is held.
- i_valid, in, 1, i_rc_filter carries a new sample this cycle.
- i_restart, in, 1, synchronous restart to ACQUIRE (clears counters and accumulators).
- i_rc_filter, in, S_IN, signed RC filter output.
- o_sync, out, 1, lock indicator.
- o_phase, out, PH_W, selected sampling phase.
- o_strobe, out, 1, one-cycle pulse: locked sample at the selected phase.
- o_sample, out, S_IN, sample accompanying o_strobe.

Behaviour:
- Reset values:
  - All outputs = 0; state = ACQUIRE.
  - Phase counter, symbol counter, loss counter, all OS accumulators and the shadow copies = 0.
- Accepted sample: i_enable && i_valid. Only accepted samples advance the phase counter (0..OS-1, wraps) and the symbol counter (increments on wrap).
- Magnitude: |x|, unsigned S_IN bits; -2^(S_IN-1) maps to 2^(S_IN-1) with no saturation.
- Accumulation: acc[phase] += |x|. Overflow is impossible by construction of ACC_W.
- Window close: the accepted sample with phase==OS-1 and symbol counter==2^WIN_LOG2-1.
  - Same cycle: shadow[k] <= acc[k], including the closing sample; live accumulators cleared to 0.
  - No sample is lost; EVAL runs in parallel with the next window.
- EVAL (one cycle after window close):
  - best = argmax(shadow); ties resolve to the lowest index.
  - pass = shadow[best] >= THR << WIN_LOG2.
- State machine:
  - ACQUIRE -> LOCKED when EVAL pass. On the next edge: o_sync=1, o_phase=best, loss counter=0.
  - ACQUIRE: a failing EVAL stays in ACQUIRE with o_phase unchanged.
  - LOCKED, EVAL pass: o_phase <= best (tracking) and loss counter cleared.
  - LOCKED, EVAL fail: loss counter +1, o_phase held. When it reaches LOSS_WIN: -> ACQUIRE, o_sync=0, loss counter=0.
  - i_restart (any state): -> ACQUIRE, o_sync=0, counters and accumulators cleared; o_phase held. i_restart has priority over a same-cycle window close or EVAL.
- Strobe:
  - When o_sync==1 and an accepted sample has phase==o_phase: o_strobe=1 and o_sample=sample, both 1 cycle after the accepted sample. Otherwise o_strobe=0.
  - o_sample holds its last value.
  - The strobe uses the o_phase value current when the sample was accepted.
- i_enable low mid-window: no state changes; the window resumes when enable returns.
- Asynchronous reset mid-operation: immediate return to reset values; no partial window survives.

Decomposition:
- Package sync_pkg:
  - state encoding typedef (ACQUIRE, LOCKED);
  - default constants: S_IN, OS, WIN_LOG2, THR, LOSS_WIN;
  - function for ACC_W.
- One sub-module, sync_argmax: combinational argmax over OS unsigned ACC_W inputs, lowest index on ties. Outputs: index and max value.

Test Plan:
- Reset: hold i_reset=0 with random input -> o_sync=0, o_phase=0, o_strobe=0, o_sample=0 throughout.
- Acquisition (OS=4, WIN_LOG2=4):
  - Stimulus: phase 2 alternates +200/-200, other phases ±10, i_valid every cycle.
  - Response: o_sync rises 2 cycles after the 64th sample, o_phase=2. Thereafter o_strobe pulses every 4 samples with o_sample=±200.
- Tie and threshold:
  - Phases 1 and 3 at ±150, others 0 -> lock with o_phase=1.
  - All phases at ±50 (< 77) -> o_sync stays 0 for 10 windows.
- Tracking and loss of lock:
  - Phase change: locked at phase 2, energy moves to phase 0 -> o_phase=0 after the next EVAL, o_sync stays 1.
  - One zero window then signal returns -> o_sync stays 1.
  - Two consecutive zero windows -> o_sync falls after the second EVAL.
- Enable gaps / restart:
  - i_enable low for 7 cycles in random bursts inside a window -> identical lock result and timing in accepted-sample count.
  - i_restart pulsed on the window-close cycle -> no lock from that window; o_sync=0.
- Boundary magnitude: phase 0 at constant -512, S_IN=10 -> no overflow; shadow[0]=512*16=8192 and lock on phase 0.
